spi_axi_txn_arbiter: RTL and testbench
======================================

# spi_axi_txn_arbiter

Shares one AXI-Lite master transaction engine between NUM_REQ register-access requesters, for example the SPI slave sequencer and a debug/UART bridge, in the core_clk domain. The block arbitrates round-robin and latches the winner's address, data and direction. It then drives the engine's init/done/error handshake with a settle window and a timeout, and returns a one-cycle response to the granted requester.

## Interface
- NUM_REQ, 2: requester count, legal range 2..4.
- ADDR_WIDTH, 20: AXI address width.
- TIMEOUT_CYCLES, 32: wait-state limit, legal range 4..255.
- core_clk  in  1  sole clock.
- core_reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request, held until req_ack.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*32  flattened write data.
- req_ack  out  NUM_REQ  one-hot, one-cycle request acceptance.
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion.
- resp_rdata  out  32  read data, valid with resp_valid.
- resp_error  out  1  AXI error or timeout, valid with resp_valid.
- resp_timeout  out  1  timeout occurred, valid with resp_valid.
- init_w_axi_txn, init_r_axi_txn  out  1  engine start pulses.
- user_awaddr, user_araddr  out  ADDR_WIDTH  engine addresses.
- user_wdata  out  32  engine write data.
- user_rdata  in  32  engine read data.
- done_w_axi_txn, done_r_axi_txn, error_w_axi_txn, error_r_axi_txn  in  1  engine status.

## Operation
- Every output is a register. Reset value of all outputs is 0. The round-robin pointer last_grant resets to NUM_REQ-1, so requester 0 wins first.
- States are IDLE, ISSUE, SETTLE1, SETTLE2, WAIT and RESP.
- IDLE:
  - If any req_valid is set, pick the first requester searching from last_grant+1, wrapping modulo NUM_REQ.
  - Latch the winner's index and direction, and latch its address into user_awaddr or user_araddr; the other address register holds.
  - For a write, latch its data into user_wdata.
  - Set last_grant to the winner, pulse req_ack[winner] and go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE: pulse init_w_axi_txn or init_r_axi_txn for exactly one cycle, then go to SETTLE1.
- SETTLE1 and SETTLE2: ignore done and error, because done from the previous transaction takes a cycle to clear.
- WAIT:
  - Increment the 8-bit timeout counter each cycle. The counter clears on entry.
  - Sample only the done/error pair that matches the latched direction.
  - On done, capture user_rdata (reads only; writes return 0) and the matching error into resp_error, then go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without done, set resp_timeout=1 and resp_error=1, return rdata=0, and go to RESP.
- RESP: pulse resp_valid[grant] for one cycle, then go to IDLE. resp_rdata, resp_error and resp_timeout hold until the next RESP.
- Boundary conditions:
  - A requester that drops req_valid before it is picked is never granted.
  - A requester that raises req_valid during a transaction waits; it is evaluated in the next IDLE.
  - If done and timeout coincide in the same cycle, done wins.
  - Wrong-direction done or error pulses are ignored.
  - Reset mid-transaction aborts it: outputs go to 0 and no response is issued. Requesters must re-request.

## Timing
- Edge 0: IDLE samples req_valid.
- Cycle 1: req_ack high; user_* registers valid.
- Cycle 2: init pulse high.
- Cycles 2-3: SETTLE1/SETTLE2.
- Cycle 4 onward: WAIT samples done.
- Minimum latency: done high in cycle 4 gives resp_valid in cycle 5. The next arbitration samples at the end of cycle 6.
- Timeout: resp_valid occurs TIMEOUT_CYCLES cycles after WAIT entry.
- One transaction is outstanding at a time. There are no back-to-back grants without the IDLE cycle.

## Structure
- Shared package spi_axi_pkg holds:
  - the typedef enum logic [2:0] for the arbiter state;
  - the default TIMEOUT_CYCLES constant;
  - the direction encoding constants.
- One sub-module, spi_axi_rr_arbiter, contains the round-robin pick. Its inputs are req_valid and last_grant; its outputs are a one-hot grant and an index. It also contains the pointer update on its grant_en input.

## Test plan
- Single read, requester 0, addr 0x00010, engine returns done_r in cycle 4 with rdata 0xDEADBEEF -> init_r pulse in cycle 2, user_araddr=0x00010, resp_valid[0] in cycle 5, rdata 0xDEADBEEF, error 0.
- Requesters 0 and 1 both request after reset, then again after completion -> grants go 0, 1, 0, with each req_ack one cycle and exclusive.
- Write from requester 1, addr 0xABCDE, data 0x12345678, error_w with done_w -> user_wdata=0x12345678, init_w pulse once, resp_error=1, resp_timeout=0.
- Engine never asserts done, TIMEOUT_CYCLES=32 -> resp_valid 32 cycles after WAIT entry with resp_timeout=1, resp_error=1, rdata 0; the arbiter then accepts the next request.
- Stale done_r held high through cycles 2-3 and deasserted, then done_r in cycle 10 -> no early completion; resp_valid in cycle 11.
- core_reset_n asserted during WAIT -> all outputs 0 immediately and no resp_valid; the next request after release is granted to requester 0.

Source files
------------

// File: rtl/spi_axi_pkg.sv
// Shared types and constants for the SPI/debug AXI-Lite transaction arbiter.
package spi_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE1,
        ST_SETTLE2,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    localparam int TIMEOUT_CYCLES_DEF = 32;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/spi_axi_txn_arbiter_if.sv
// Requester and AXI-Lite engine signals shared by the arbiter and its environment.
interface spi_axi_txn_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 20
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*32-1:0]         req_wdata;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [31:0]                   resp_rdata;
    logic                          resp_error;
    logic                          resp_timeout;
    logic                          init_w_axi_txn;
    logic                          init_r_axi_txn;
    logic [ADDR_WIDTH-1:0]         user_awaddr;
    logic [ADDR_WIDTH-1:0]         user_araddr;
    logic [31:0]                   user_wdata;
    logic [31:0]                   user_rdata;
    logic                          done_w_axi_txn;
    logic                          done_r_axi_txn;
    logic                          error_w_axi_txn;
    logic                          error_r_axi_txn;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  user_rdata, done_w_axi_txn, done_r_axi_txn, error_w_axi_txn, error_r_axi_txn,
        output req_ack, resp_valid, resp_rdata, resp_error, resp_timeout,
        output init_w_axi_txn, init_r_axi_txn, user_awaddr, user_araddr, user_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output user_rdata, done_w_axi_txn, done_r_axi_txn, error_w_axi_txn, error_r_axi_txn,
        input  req_ack, resp_valid, resp_rdata, resp_error, resp_timeout,
        input  init_w_axi_txn, init_r_axi_txn, user_awaddr, user_araddr, user_wdata
    );

endinterface

// File: rtl/spi_axi_rr_arbiter.sv
// Round-robin pick starting after last_grant; the pointer advances only when grant_en accepts the pick.
module spi_axi_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               grant_en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);
    logic [IDX_W-1:0]   last_grant;
    logic               found;
    int                 cand;
    logic [NUM_REQ-1:0] cand_mask;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_mask = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_mask = NUM_REQ'(1) << cand;
            if (!found && ((req_valid & cand_mask) != '0)) begin
                found     = 1'b1;
                grant     = cand_mask;
                grant_idx = IDX_W'(cand);
            end
        end
    end

    // Resetting to the highest index makes requester 0 the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        last_grant <= IDX_W'(NUM_REQ - 1);
        else if (grant_en) last_grant <= grant_idx;
    end

endmodule

// File: rtl/spi_axi_txn_arbiter.sv
// Shares one AXI-Lite master engine between NUM_REQ requesters: arbitrate, issue, settle, wait, respond.
module spi_axi_txn_arbiter
    import spi_axi_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 20,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  core_clk,
    input  logic                  core_reset_n,
    spi_axi_txn_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

    arb_state_t             state, state_next;
    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       grant_q;
    logic                   grant_en;
    logic                   dir_q;
    logic [7:0]             wait_cnt;
    logic                   done_sel;
    logic                   err_sel;
    logic                   tmo_hit;
    logic                   sel_write;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [31:0]            sel_wdata;

    spi_axi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk       (core_clk),
        .rst_n     (core_reset_n),
        .req_valid (bus.req_valid),
        .grant_en  (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign sel_write = |(bus.req_write & grant);
    assign done_sel  = (dir_q == DIR_WRITE) ? bus.done_w_axi_txn  : bus.done_r_axi_txn;
    assign err_sel   = (dir_q == DIR_WRITE) ? bus.error_w_axi_txn : bus.error_r_axi_txn;
    assign tmo_hit   = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge core_clk or negedge core_reset_n) begin
        if (!core_reset_n) state <= ST_IDLE;
        else               state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    grant_en   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE:   state_next = ST_SETTLE1;
            // Engine done from the previous transaction may still be high here.
            ST_SETTLE1: state_next = ST_SETTLE2;
            ST_SETTLE2: state_next = ST_WAIT;
            ST_WAIT:    if (done_sel || tmo_hit) state_next = ST_RESP;
            ST_RESP:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            bus.req_ack        <= '0;
            bus.resp_valid     <= '0;
            bus.resp_rdata     <= '0;
            bus.resp_error     <= 1'b0;
            bus.resp_timeout   <= 1'b0;
            bus.init_w_axi_txn <= 1'b0;
            bus.init_r_axi_txn <= 1'b0;
            bus.user_awaddr    <= '0;
            bus.user_araddr    <= '0;
            bus.user_wdata     <= '0;
            grant_q            <= '0;
            dir_q              <= DIR_READ;
            wait_cnt           <= '0;
        end else begin
            bus.req_ack        <= '0;
            bus.resp_valid     <= '0;
            bus.init_w_axi_txn <= 1'b0;
            bus.init_r_axi_txn <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_en) begin
                        grant_q     <= grant_idx;
                        dir_q       <= sel_write;
                        bus.req_ack <= grant;
                        if (sel_write) begin
                            bus.user_awaddr <= sel_addr;
                            bus.user_wdata  <= sel_wdata;
                        end else begin
                            bus.user_araddr <= sel_addr;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (dir_q == DIR_WRITE) bus.init_w_axi_txn <= 1'b1;
                    else                    bus.init_r_axi_txn <= 1'b1;
                end
                ST_SETTLE2: wait_cnt <= '0;
                ST_WAIT: begin
                    // Done takes priority over a timeout landing in the same cycle.
                    if (done_sel) begin
                        bus.resp_valid   <= NUM_REQ'(1) << grant_q;
                        bus.resp_rdata   <= (dir_q == DIR_WRITE) ? 32'h0 : bus.user_rdata;
                        bus.resp_error   <= err_sel;
                        bus.resp_timeout <= 1'b0;
                    end else if (tmo_hit) begin
                        bus.resp_valid   <= NUM_REQ'(1) << grant_q;
                        bus.resp_rdata   <= 32'h0;
                        bus.resp_error   <= 1'b1;
                        bus.resp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_axi_txn_arbiter.sv
// Directed bench for spi_axi_txn_arbiter: arbitration order, engine handshake, timeout and reset abort.
module tb_spi_axi_txn_arbiter;
    logic core_clk = 1'b0;
    logic core_reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [111:0] all_out;

    always #5 core_clk = ~core_clk;

    spi_axi_txn_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(20)) bus ();

    spi_axi_txn_arbiter #(
        .NUM_REQ        (2),
        .ADDR_WIDTH     (20),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .core_clk     (core_clk),
        .core_reset_n (core_reset_n),
        .bus          (bus.master)
    );

    assign all_out = {bus.req_ack, bus.resp_valid, bus.resp_rdata, bus.resp_error, bus.resp_timeout,
                      bus.init_w_axi_txn, bus.init_r_axi_txn, bus.user_awaddr, bus.user_araddr,
                      bus.user_wdata};

    task automatic tick;
        @(posedge core_clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.req_valid       = '0;
        bus.req_write       = '0;
        bus.req_addr        = '0;
        bus.req_wdata       = '0;
        bus.user_rdata      = '0;
        bus.done_w_axi_txn  = 1'b0;
        bus.done_r_axi_txn  = 1'b0;
        bus.error_w_axi_txn = 1'b0;
        bus.error_r_axi_txn = 1'b0;
    endtask

    task automatic set_req(input logic idx, input logic w, input logic [19:0] a, input logic [31:0] d);
        bus.req_valid[idx] = 1'b1;
        bus.req_write[idx] = w;
        if (idx) begin
            bus.req_addr[39:20]  = a;
            bus.req_wdata[63:32] = d;
        end else begin
            bus.req_addr[19:0]   = a;
            bus.req_wdata[31:0]  = d;
        end
    endtask

    // Called in cycle 2 of a transaction; raises done in cycle 4, returns in cycle 5.
    task automatic engine_done(input logic w, input logic err, input logic [31:0] rd);
        repeat (2) tick();
        if (w) begin
            bus.done_w_axi_txn  = 1'b1;
            bus.error_w_axi_txn = err;
        end else begin
            bus.done_r_axi_txn  = 1'b1;
            bus.error_r_axi_txn = err;
        end
        bus.user_rdata = rd;
        tick();
        bus.done_w_axi_txn  = 1'b0;
        bus.done_r_axi_txn  = 1'b0;
        bus.error_w_axi_txn = 1'b0;
        bus.error_r_axi_txn = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        core_reset_n = 1'b0;
        repeat (2) tick();
        core_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (all_out !== 112'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", all_out);
        end
    endtask

    task automatic test_single_read;
        set_req(1'b0, 1'b0, 20'h00010, 32'h0);
        tick();
        checks++;
        if (bus.req_ack !== 2'b01) begin errors++; $display("FAIL rd_ack got %b want 01", bus.req_ack); end
        checks++;
        if (bus.user_araddr !== 20'h00010) begin errors++; $display("FAIL rd_araddr got %h want 00010", bus.user_araddr); end
        bus.req_valid[0] = 1'b0;
        tick();
        checks++;
        if ({bus.init_r_axi_txn, bus.init_w_axi_txn} !== 2'b10) begin
            errors++; $display("FAIL rd_init_c2 got %b want 10", {bus.init_r_axi_txn, bus.init_w_axi_txn});
        end
        tick();
        checks++;
        if (bus.init_r_axi_txn !== 1'b0) begin errors++; $display("FAIL rd_init_c3 got %b want 0", bus.init_r_axi_txn); end
        tick();
        bus.done_r_axi_txn = 1'b1;
        bus.user_rdata     = 32'hDEADBEEF;
        checks++;
        if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL rd_resp_c4 got %b want 00", bus.resp_valid); end
        tick();
        bus.done_r_axi_txn = 1'b0;
        checks++;
        if (bus.resp_valid !== 2'b01) begin errors++; $display("FAIL rd_resp_c5 got %b want 01", bus.resp_valid); end
        checks++;
        if ({bus.resp_rdata, bus.resp_error, bus.resp_timeout} !== {32'hDEADBEEF, 2'b00}) begin
            errors++; $display("FAIL rd_result got %h/%b/%b want deadbeef/0/0", bus.resp_rdata, bus.resp_error, bus.resp_timeout);
        end
        tick();
        checks++;
        if (bus.resp_valid !== 2'b00 || bus.resp_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_resp_c6 got %b/%h want 00/deadbeef", bus.resp_valid, bus.resp_rdata);
        end
    endtask

    task automatic test_round_robin;
        do_reset();
        set_req(1'b0, 1'b0, 20'h00100, 32'h0);
        set_req(1'b1, 1'b0, 20'h00200, 32'h0);
        tick();
        checks++;
        if (bus.req_ack !== 2'b01) begin errors++; $display("FAIL rr_ack1 got %b want 01", bus.req_ack); end
        bus.req_valid[0] = 1'b0;
        tick();
        checks++;
        if (bus.req_ack !== 2'b00) begin errors++; $display("FAIL rr_ack1_pulse got %b want 00", bus.req_ack); end
        engine_done(1'b0, 1'b0, 32'hA0A0A0A0);
        checks++;
        if (bus.resp_valid !== 2'b01) begin errors++; $display("FAIL rr_resp1 got %b want 01", bus.resp_valid); end
        tick();
        tick();
        checks++;
        if (bus.req_ack !== 2'b10) begin errors++; $display("FAIL rr_ack2 got %b want 10", bus.req_ack); end
        checks++;
        if (bus.user_araddr !== 20'h00200) begin errors++; $display("FAIL rr_araddr2 got %h want 00200", bus.user_araddr); end
        bus.req_valid = 2'b11;
        tick();
        checks++;
        if (bus.req_ack !== 2'b00) begin errors++; $display("FAIL rr_ack2_pulse got %b want 00", bus.req_ack); end
        engine_done(1'b0, 1'b0, 32'hB0B0B0B0);
        checks++;
        if (bus.resp_valid !== 2'b10) begin errors++; $display("FAIL rr_resp2 got %b want 10", bus.resp_valid); end
        tick();
        tick();
        checks++;
        if (bus.req_ack !== 2'b01) begin errors++; $display("FAIL rr_ack3 got %b want 01", bus.req_ack); end
        bus.req_valid = 2'b00;
        tick();
        engine_done(1'b0, 1'b0, 32'hC0C0C0C0);
        checks++;
        if (bus.resp_valid !== 2'b01) begin errors++; $display("FAIL rr_resp3 got %b want 01", bus.resp_valid); end
        tick();
        tick();
        checks++;
        if (bus.req_ack !== 2'b00) begin errors++; $display("FAIL rr_dropped_req got %b want 00", bus.req_ack); end
    endtask

    task automatic test_write;
        set_req(1'b1, 1'b1, 20'hABCDE, 32'h12345678);
        tick();
        checks++;
        if (bus.req_ack !== 2'b10) begin errors++; $display("FAIL wr_ack got %b want 10", bus.req_ack); end
        checks++;
        if ({bus.user_awaddr, bus.user_wdata} !== {20'hABCDE, 32'h12345678}) begin
            errors++; $display("FAIL wr_latch got %h/%h want abcde/12345678", bus.user_awaddr, bus.user_wdata);
        end
        checks++;
        if (bus.user_araddr !== 20'h00100) begin errors++; $display("FAIL wr_araddr_hold got %h want 00100", bus.user_araddr); end
        bus.req_valid = 2'b00;
        tick();
        checks++;
        if ({bus.init_w_axi_txn, bus.init_r_axi_txn} !== 2'b10) begin
            errors++; $display("FAIL wr_init_c2 got %b want 10", {bus.init_w_axi_txn, bus.init_r_axi_txn});
        end
        tick();
        checks++;
        if (bus.init_w_axi_txn !== 1'b0) begin errors++; $display("FAIL wr_init_c3 got %b want 0", bus.init_w_axi_txn); end
        tick();
        bus.done_w_axi_txn  = 1'b1;
        bus.error_w_axi_txn = 1'b1;
        bus.user_rdata      = 32'hFFFFFFFF;
        tick();
        bus.done_w_axi_txn  = 1'b0;
        bus.error_w_axi_txn = 1'b0;
        checks++;
        if (bus.resp_valid !== 2'b10) begin errors++; $display("FAIL wr_resp got %b want 10", bus.resp_valid); end
        checks++;
        if ({bus.resp_rdata, bus.resp_error, bus.resp_timeout} !== {32'h0, 2'b10}) begin
            errors++; $display("FAIL wr_result got %h/%b/%b want 0/1/0", bus.resp_rdata, bus.resp_error, bus.resp_timeout);
        end
        tick();
    endtask

    task automatic test_timeout;
        int cyc;
        set_req(1'b0, 1'b0, 20'h00123, 32'h0);
        bus.user_rdata = 32'hCAFEF00D;
        tick();
        cyc = 1;
        checks++;
        if (bus.req_ack !== 2'b01) begin errors++; $display("FAIL tmo_ack got %b want 01", bus.req_ack); end
        bus.req_valid = 2'b00;
        while (cyc < 36) begin
            tick();
            cyc++;
            if (cyc == 6) begin
                bus.done_w_axi_txn  = 1'b1;
                bus.error_w_axi_txn = 1'b1;
            end
            if (cyc == 7) begin
                bus.done_w_axi_txn  = 1'b0;
                bus.error_w_axi_txn = 1'b0;
            end
            if (cyc == 35) begin
                checks++;
                if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL tmo_early got %b want 00", bus.resp_valid); end
            end
        end
        checks++;
        if (bus.resp_valid !== 2'b01) begin errors++; $display("FAIL tmo_resp got %b want 01", bus.resp_valid); end
        checks++;
        if ({bus.resp_rdata, bus.resp_error, bus.resp_timeout} !== {32'h0, 2'b11}) begin
            errors++; $display("FAIL tmo_result got %h/%b/%b want 0/1/1", bus.resp_rdata, bus.resp_error, bus.resp_timeout);
        end
        set_req(1'b1, 1'b0, 20'h00456, 32'h0);
        tick();
        tick();
        checks++;
        if (bus.req_ack !== 2'b10 || bus.user_araddr !== 20'h00456) begin
            errors++; $display("FAIL tmo_next_ack got %b/%h want 10/00456", bus.req_ack, bus.user_araddr);
        end
        bus.req_valid = 2'b00;
        tick();
        engine_done(1'b0, 1'b0, 32'h11111111);
        checks++;
        if ({bus.resp_valid, bus.resp_rdata, bus.resp_error, bus.resp_timeout} !== {2'b10, 32'h11111111, 2'b00}) begin
            errors++; $display("FAIL tmo_next_resp got %b/%h/%b/%b want 10/11111111/0/0",
                               bus.resp_valid, bus.resp_rdata, bus.resp_error, bus.resp_timeout);
        end
        tick();
    endtask

    task automatic test_done_timeout_tie;
        int cyc;
        set_req(1'b0, 1'b0, 20'h00321, 32'h0);
        tick();
        cyc = 1;
        bus.req_valid = 2'b00;
        while (cyc < 36) begin
            tick();
            cyc++;
            if (cyc == 35) begin
                bus.done_r_axi_txn = 1'b1;
                bus.user_rdata     = 32'h0BADC0DE;
            end
        end
        bus.done_r_axi_txn = 1'b0;
        checks++;
        if ({bus.resp_valid, bus.resp_rdata, bus.resp_error, bus.resp_timeout} !== {2'b01, 32'h0BADC0DE, 2'b00}) begin
            errors++; $display("FAIL tie_resp got %b/%h/%b/%b want 01/0badc0de/0/0",
                               bus.resp_valid, bus.resp_rdata, bus.resp_error, bus.resp_timeout);
        end
        tick();
    endtask

    task automatic test_stale_done;
        int cyc;
        set_req(1'b0, 1'b0, 20'h00777, 32'h0);
        tick();
        cyc = 1;
        bus.req_valid = 2'b00;
        tick();
        cyc = 2;
        bus.done_r_axi_txn = 1'b1;
        bus.user_rdata     = 32'h55AA55AA;
        tick();
        cyc = 3;
        set_req(1'b1, 1'b0, 20'h00888, 32'h0);
        while (cyc < 10) begin
            tick();
            cyc++;
            if (cyc == 4) bus.done_r_axi_txn = 1'b0;
            checks++;
            if (bus.resp_valid !== 2'b00 || bus.req_ack !== 2'b00) begin
                errors++; $display("FAIL stale_early_c%0d got %b/%b want 00/00", cyc, bus.resp_valid, bus.req_ack);
            end
            if (cyc == 10) bus.done_r_axi_txn = 1'b1;
        end
        tick();
        bus.done_r_axi_txn = 1'b0;
        checks++;
        if (bus.resp_valid !== 2'b01 || bus.resp_rdata !== 32'h55AA55AA) begin
            errors++; $display("FAIL stale_resp_c11 got %b/%h want 01/55aa55aa", bus.resp_valid, bus.resp_rdata);
        end
        tick();
        tick();
        checks++;
        if (bus.req_ack !== 2'b10) begin errors++; $display("FAIL stale_waiting_ack got %b want 10", bus.req_ack); end
        bus.req_valid = 2'b00;
        tick();
        engine_done(1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid;
        set_req(1'b0, 1'b0, 20'h00999, 32'h0);
        tick();
        bus.req_valid = 2'b00;
        repeat (5) tick();
        core_reset_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 112'h0) begin errors++; $display("FAIL rst_async got %h want 0", all_out); end
        bus.done_r_axi_txn = 1'b1;
        repeat (2) tick();
        checks++;
        if (all_out !== 112'h0) begin errors++; $display("FAIL rst_hold got %h want 0", all_out); end
        bus.done_r_axi_txn = 1'b0;
        core_reset_n = 1'b1;
        tick();
        checks++;
        if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL rst_no_resp got %b want 00", bus.resp_valid); end
        set_req(1'b0, 1'b0, 20'h00AAA, 32'h0);
        set_req(1'b1, 1'b0, 20'h00BBB, 32'h0);
        tick();
        checks++;
        if (bus.req_ack !== 2'b01) begin errors++; $display("FAIL rst_ptr_ack got %b want 01", bus.req_ack); end
        bus.req_valid = 2'b00;
        tick();
        engine_done(1'b0, 1'b0, 32'h77777777);
        checks++;
        if (bus.resp_valid !== 2'b01 || bus.resp_rdata !== 32'h77777777) begin
            errors++; $display("FAIL rst_after_resp got %b/%h want 01/77777777", bus.resp_valid, bus.resp_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_timeout();
        test_done_timeout_tie();
        test_stale_done();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after 100000 time units");
        $fatal(1);
    end

endmodule
